register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
Next-generation parametrised register file for the datapath. It provides configurable width, depth and read-port count, plus two write ports with byte enables. Optional features are a hardwired-zero register 0, write-to-read bypass, registered read outputs, and a sequenced bulk-clear engine with a busy flag. It sits in the decode/writeback stage in place of the single-write, two-read register file.

Parameters:
WORD_LENGTH, 32, data width in bits; must be a multiple of 8.
N, 32, number of registers; power of two, at least 2.
READ_PORTS, 2, number of independent read ports, 1..4.
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
BYPASS, 1, 1 = same-cycle write data is forwarded to combinational reads.
REGISTERED_READ, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency.
Derived localparams: AW = clog2(N); BE_W = WORD_LENGTH/8.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
RegWrite0  in  1  write enable, port 0.
WriteRegister0  in  AW  write address, port 0.
WriteData0  in  WORD_LENGTH  write data, port 0.
ByteEnable0  in  BE_W  per-byte write enable, port 0.
RegWrite1  in  1  write enable, port 1.
WriteRegister1  in  AW  write address, port 1.
WriteData1  in  WORD_LENGTH  write data, port 1.
ByteEnable1  in  BE_W  per-byte write enable, port 1.
ReadRegister  in  READ_PORTS*AW  packed read addresses; port k occupies slice [k*AW +: AW].
ReadData  out  READ_PORTS*WORD_LENGTH  packed read data; port k occupies slice [k*WORD_LENGTH +: WORD_LENGTH].
Clear  in  1  single-cycle request to zero all registers.
Busy  out  1  clear sweep in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0; FSM = IDLE; sweep counter = 0.
  - Busy = 0; registered ReadData = 0.
- Write, IDLE state, per edge:
  - byte b of reg[a] is updated if RegWrite0 & ByteEnable0[b] & a==WriteRegister0 (port 0), or the same condition on port 1.
  - Bytes without an enable hold their value.
- Write collision:
  - both ports write the same address and the same byte: port 1 wins.
  - non-overlapping bytes from each port merge.
- ZERO_REG=1:
  - writes to address 0 are discarded.
  - reads of address 0 return 0, including the bypass path.
- Combinational read (REGISTERED_READ=0):
  - ReadData[k] = reg[ReadRegister[k]].
  - If BYPASS=1, FSM=IDLE and a write targets that address this cycle, the enabled bytes come from the write data (port 1 over port 0); the rest come from the array.
  - If BYPASS=0, the pre-write value is returned.
- Registered read (REGISTERED_READ=1):
  - ReadData[k] is captured at the edge and reflects the value after that edge's writes (write-first).
  - BYPASS is ignored.
- FSM IDLE -> CLEARING:
  - Transition when Clear=1 is sampled at an edge in IDLE.
  - Writes presented on that edge are dropped (Clear has priority).
  - Busy=1 from that edge; counter = 0.
- CLEARING, each edge:
  - reg[counter] <= 0; counter++.
  - After clearing reg N-1: return to IDLE, Busy=0. Busy is high for exactly N cycles.
  - Writes are dropped and bypass is disabled.
  - Reads return current array contents (partially cleared).
  - Clear is ignored.
- Reset mid-sweep: immediate IDLE, Busy=0, all registers 0.
- Address wrap: not applicable, since N is a power of two and every address is valid.

Test Plan:
1. Hold reset=0 for 3 cycles, release, read all 32 addresses on both ports -> every ReadData = 0; Busy = 0.
2. Write reg2 = 7 with ByteEnable0 = 4'hF. Next cycle read port0 = 2 -> 7. In a later cycle, write reg4 = 20 while port1 reads 4 in the same cycle (BYPASS=1, REGISTERED_READ=0) -> port1 reads 20 before the edge.
3. Write reg0 = 32'hFFFFFFFF (ZERO_REG=1) -> reg0 reads 0. Bypass during the write also returns 0.
4. Write reg25 = 32'h11223344 (BE 4'hF), then 32'hAABBCCDD with BE 4'b0101 -> reg25 reads 32'h11BB33DD.
5. Same edge: port0 writes reg31 = 32'hCAFEBABE (BE 4'hF) and port1 writes reg31 = 32'h12345678 (BE 4'b0011) -> reg31 reads 32'hCAFE5678.
6. Fill reg1..reg31 with nonzero values, then pulse Clear for 1 cycle:
   - Busy is high for exactly 32 cycles.
   - A write of reg5 = 9 during Busy is dropped, and reg5 reads 0 after the sweep.
   - In a repeat run, asserting reset=0 at sweep cycle 10 drops Busy immediately and all registers read 0.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port register file.
//   Two byte-enabled write ports. Port 1 wins on a byte collision. READ_PORTS
//   read ports give combinational reads (optional write bypass) or registered
//   reads (write-first). An optional hardwired-zero register 0 is provided. A
//   sequenced bulk-clear engine zeroes one register per cycle while Busy is high.
// Ports:
//   clk, reset (async, active-low)
//   RegWrite0/1, WriteRegister0/1, WriteData0/1, ByteEnable0/1 : write ports
//   ReadRegister : packed read addresses, port k at [k*AW +: AW]
//   ReadData     : packed read data, port k at [k*WORD_LENGTH +: WORD_LENGTH]
//   Clear : single-cycle request to start the clear sweep
//   Busy  : clear sweep in progress
module register_file_mp #(
  parameter int unsigned WORD_LENGTH     = 32,
  parameter int unsigned N               = 32,
  parameter int unsigned READ_PORTS      = 2,
  parameter bit          ZERO_REG        = 1'b1,
  parameter bit          BYPASS          = 1'b1,
  parameter bit          REGISTERED_READ = 1'b0,
  localparam int unsigned AW   = $clog2(N),
  localparam int unsigned BE_W = WORD_LENGTH / 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              RegWrite0,
  input  logic [AW-1:0]                     WriteRegister0,
  input  logic [WORD_LENGTH-1:0]            WriteData0,
  input  logic [BE_W-1:0]                   ByteEnable0,
  input  logic                              RegWrite1,
  input  logic [AW-1:0]                     WriteRegister1,
  input  logic [WORD_LENGTH-1:0]            WriteData1,
  input  logic [BE_W-1:0]                   ByteEnable1,
  input  logic [READ_PORTS*AW-1:0]          ReadRegister,
  output logic [READ_PORTS*WORD_LENGTH-1:0] ReadData,
  input  logic                              Clear,
  output logic                              Busy
);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t                 state, stateNext;
  logic [AW-1:0]          sweepIdx;
  logic [WORD_LENGTH-1:0] regs [N];
  logic                   writeActive;
  logic                   lastSweep;

  // Value a register would hold after this cycle's writes. Port 1 is applied
  // after port 0, so it wins any byte both ports enable.
  function automatic logic [WORD_LENGTH-1:0] mergeWrites(
    input logic [AW-1:0]          addr,
    input logic [WORD_LENGTH-1:0] cur
  );
    logic [WORD_LENGTH-1:0] res;
    res = cur;
    if (!(ZERO_REG && addr == '0)) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (RegWrite0 && ByteEnable0[b] && WriteRegister0 == addr)
          res[b*8 +: 8] = WriteData0[b*8 +: 8];
        if (RegWrite1 && ByteEnable1[b] && WriteRegister1 == addr)
          res[b*8 +: 8] = WriteData1[b*8 +: 8];
      end
    end
    return res;
  endfunction

  always_comb begin
    writeActive = (state == IDLE) && !Clear;
    lastSweep   = (sweepIdx == AW'(N - 1));
    Busy        = (state == CLEARING);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (Clear)     stateNext = CLEARING;
      CLEARING: if (lastSweep) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // The counter is held at 0 outside the sweep. It wraps from N-1 back to 0
  // on the final sweep edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sweepIdx <= '0;
    end else begin
      state    <= stateNext;
      sweepIdx <= (state == CLEARING) ? sweepIdx + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (writeActive)
          regs[i] <= mergeWrites(AW'(i), regs[i]);
        else if (state == CLEARING && sweepIdx == AW'(i))
          regs[i] <= '0;
      end
    end
  end

  generate
    if (REGISTERED_READ) begin : gRegRead
      logic [READ_PORTS*WORD_LENGTH-1:0] readNext;

      // Capture the post-edge contents so a read sees the same edge's writes.
      always_comb begin
        readNext = '0;
        for (int unsigned k = 0; k < READ_PORTS; k++) begin
          logic [AW-1:0]          addr;
          logic [WORD_LENGTH-1:0] val;
          addr = ReadRegister[k*AW +: AW];
          val  = regs[addr];
          if (writeActive)
            val = mergeWrites(addr, val);
          else if (state == CLEARING && sweepIdx == addr)
            val = '0;
          if (ZERO_REG && addr == '0)
            val = '0;
          readNext[k*WORD_LENGTH +: WORD_LENGTH] = val;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) ReadData <= '0;
        else        ReadData <= readNext;
      end
    end else begin : gCombRead
      always_comb begin
        ReadData = '0;
        for (int unsigned k = 0; k < READ_PORTS; k++) begin
          logic [AW-1:0]          addr;
          logic [WORD_LENGTH-1:0] val;
          addr = ReadRegister[k*AW +: AW];
          val  = regs[addr];
          if (BYPASS && state == IDLE)
            val = mergeWrites(addr, val);
          if (ZERO_REG && addr == '0)
            val = '0;
          ReadData[k*WORD_LENGTH +: WORD_LENGTH] = val;
        end
      end
    end
  endgenerate

endmodule
